mod4_sum_sink: RTL

Receive-side endpoint for the mod4 Q2.14 adder's result stream: accepts `{tdata, overflow}` beats, saturates overflowed results according to the signed/unsigned mode, and buffers them in a small FIFO. It re-emits the results as an AXI-stream with `tlast` framing, and keeps a saturating count of overflow events for status readback. It sits between the adder output and the downstream consumer (DMA/packetizer).

---
 rtl/mod4_pkg.sv | 31 +++
 rtl/mod4_sync_fifo.sv | 64 ++++++
 rtl/mod4_sum_sink.sv | 75 +++++++
 3 files changed

// File: rtl/mod4_pkg.sv
// Shared Q2.14 / U2.14 format constants and the overflow saturation rule
// used by the mod4 adder and its result sink.
package mod4_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 14;

    localparam logic [Q_W-1:0] Q_SMAX = 16'h7FFF;
    localparam logic [Q_W-1:0] Q_SMIN = 16'h8000;
    localparam logic [Q_W-1:0] Q_UMAX = 16'hFFFF;

    // A signed result that wrapped past the top reads as negative, and vice versa.
    function automatic logic [Q_W-1:0] mod4_saturate(
        input logic signed [Q_W-1:0] data,
        input logic                  ovf,
        input logic                  sign
    );
        logic [Q_W-1:0] res;
        res = data;
        if (ovf) begin
            if (!sign)
                res = Q_UMAX;
            else if (data < 0)
                res = Q_SMAX;
            else
                res = Q_SMIN;
        end
        return res;
    endfunction

endpackage

// File: rtl/mod4_sync_fifo.sv
// Circular FIFO with a registered show-ahead read stage; level counts every
// held entry including the one currently presented on rd_data.
module mod4_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         full,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr, rptr_nxt;
    logic [LVL_W-1:0] count, count_nxt, avail;
    logic [WIDTH-1:0] rd_q;
    logic             full_q, out_vld, push, pop;

    assign push      = wr_en && !full_q;
    assign pop       = rd_en && out_vld;
    assign rptr_nxt  = rptr + PTR_W'(pop);
    assign count_nxt = count + LVL_W'(push) - LVL_W'(pop);
    // Entries already in memory once this cycle's pop retires; a same-cycle
    // write is not visible to the output stage until the following edge.
    assign avail     = count - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full_q  <= 1'b1;
            out_vld <= 1'b0;
            rd_q    <= '0;
        end else begin
            wptr    <= wptr + PTR_W'(push);
            rptr    <= rptr_nxt;
            count   <= count_nxt;
            full_q  <= (count_nxt == LVL_W'(DEPTH));
            out_vld <= (avail != '0);
            if (avail != '0)
                rd_q <= mem[rptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    assign full    = full_q;
    assign empty   = !out_vld;
    assign rd_data = rd_q;
    assign level   = count;

endmodule

// File: rtl/mod4_sum_sink.sv
// Receive endpoint for the mod4 adder: saturates overflowed results, buffers
// them, re-emits them as framed AXI-stream and counts overflow events.
module mod4_sum_sink
    import mod4_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [Q_W-1:0]               s_tdata,
    input  logic                         s_overflow,
    input  logic                         s_sign,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [Q_W-1:0]               m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    input  logic                         ovf_clr,
    output logic [Q_W-1:0]               ovf_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [Q_W-1:0]  sat_data_p0;
    logic            fifo_full, fifo_empty;
    logic            s_acc, m_xfer, ovf_hit, frame_end;
    logic [FC_W-1:0] frame_cnt;

    assign s_tready    = !fifo_full;
    assign s_acc       = s_tvalid && s_tready;
    assign ovf_hit     = s_acc && s_overflow;
    assign sat_data_p0 = mod4_saturate(s_tdata, s_overflow, s_sign);

    // p0 -> FIFO: saturated beat enters storage; output stage is registered
    mod4_sync_fifo #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (s_tvalid),
        .wr_data (sat_data_p0),
        .full    (fifo_full),
        .rd_en   (m_tready),
        .rd_data (m_tdata),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign m_tvalid  = !fifo_empty;
    assign m_xfer    = m_tvalid && m_tready;
    assign frame_end = (frame_cnt == FC_W'(FRAME_LEN-1));
    assign m_tlast   = frame_end && m_tvalid;

    always_ff @(posedge clk) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (m_xfer)
            frame_cnt <= frame_end ? '0 : frame_cnt + FC_W'(1);
    end

    // Clear takes priority but still counts a coincident overflow beat.
    always_ff @(posedge clk) begin
        if (!reset_n)
            ovf_count <= '0;
        else if (ovf_clr)
            ovf_count <= {{(Q_W-1){1'b0}}, ovf_hit};
        else if (ovf_hit && ovf_count != Q_UMAX)
            ovf_count <= ovf_count + 16'd1;
    end

endmodule
